// File: rtl/datapath_trace_monitor.sv
// Retirement trace monitor: captures one {pc, instr, result, flags} entry per
// RUN cycle into a FIFO and stops on ecall, a spinning PC, or a cycle budget.
module datapath_trace_monitor #(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int HALT_REPEAT    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [XLEN-1:0]            pc,
    input  logic [31:0]                instr,
    input  logic                       reg_write,
    input  logic [XLEN-1:0]            alu_out,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic                       trace_ready,
    output logic                       trace_valid,
    output logic [XLEN-1:0]            trace_pc,
    output logic [31:0]                trace_instr,
    output logic [XLEN-1:0]            trace_result,
    output logic [2:0]                 trace_flags,
    output logic [31:0]                retired_count,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       halted,
    output logic                       timeout,
    output logic                       overflow,
    output logic [1:0]                 dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(HALT_REPEAT + 1);
    localparam logic [31:0] ECALL = 32'h0000_0073;

    typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEOUT} state_t;

    // Handshake: an entry leaves the FIFO on a rising edge where
    // trace_valid && trace_ready; trace_valid is purely registered state.

    state_t          state;
    logic [XLEN-1:0] mem_pc     [DEPTH];
    logic [31:0]     mem_instr  [DEPTH];
    logic [XLEN-1:0] mem_result [DEPTH];
    logic [2:0]      mem_flags  [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] prev_pc;
    logic [RW-1:0]   same_cnt;
    logic [TW-1:0]   run_cnt;

    logic capture, pop, full, push, pc_repeat, halt_hit, time_hit;

    always_comb begin
        capture   = (state == RUN);
        pop       = (count != '0) && trace_ready;
        full      = (count == CW'(DEPTH));
        push      = capture && (!full || pop);
        pc_repeat = (pc == prev_pc);
        halt_hit  = capture && ((instr == ECALL) ||
                    (pc_repeat && (same_cnt == RW'(HALT_REPEAT - 1))));
        time_hit  = capture && (run_cnt == TW'(TIMEOUT_CYCLES - 1));
    end

    // Storage needs no reset; validity is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_pc[wr_ptr]     <= pc;
            mem_instr[wr_ptr]  <= instr;
            mem_result[wr_ptr] <= alu_out;
            mem_flags[wr_ptr]  <= {mem_write, mem_read, reg_write};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            prev_pc       <= '0;
            same_cnt      <= '0;
            run_cnt       <= '0;
            retired_count <= '0;
            halted        <= 1'b0;
            timeout       <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    // Halt takes priority when both stop conditions coincide.
                    if (halt_hit) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (time_hit) begin
                        state   <= TIMEOUT;
                        timeout <= 1'b1;
                    end
                end
                default: state <= state;
            endcase

            if (capture) begin
                retired_count <= retired_count + 32'd1;
                prev_pc       <= pc;
                same_cnt      <= pc_repeat ? same_cnt + RW'(1) : '0;
                run_cnt       <= run_cnt + TW'(1);
                if (full && !pop) overflow <= 1'b1;
            end

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    assign trace_valid  = (count != '0);
    assign trace_pc     = mem_pc[rd_ptr];
    assign trace_instr  = mem_instr[rd_ptr];
    assign trace_result = mem_result[rd_ptr];
    assign trace_flags  = mem_flags[rd_ptr];
    assign fifo_count   = count;
    assign dbg_state    = state;

endmodule

// File: doc/datapath_trace_monitor.md
DATAPATH_TRACE_MONITOR -- requirements
Module: datapath_trace_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of PC and ALU result.
REQ-002 SHALL have parameter DEPTH, default 16, trace FIFO entries, power of two, >= 2.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 200, RUN cycles before timeout.
REQ-004 SHALL have parameter HALT_REPEAT, default 4, consecutive same-PC cycles that signal halt.
REQ-005 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port pc  input  XLEN  PC of the instruction executing this cycle.
REQ-008 SHALL have port instr  input  32  instruction word executing this cycle.
REQ-009 SHALL have port reg_write  input  1  register-file write enable this cycle.
REQ-010 SHALL have port alu_out  input  XLEN  ALU result this cycle.
REQ-011 SHALL have port mem_read, mem_write  input  1 each  data-memory strobes this cycle.
REQ-012 SHALL have port trace_ready  input  1  consumer accepts the head trace entry.
REQ-013 SHALL have port trace_valid  output  1  FIFO non-empty.
REQ-014 SHALL have port trace_pc, trace_instr, trace_result  output  XLEN/32/XLEN  head entry fields.
REQ-015 SHALL have port trace_flags  output  3  head entry {mem_write, mem_read, reg_write}.
REQ-016 SHALL have port retired_count  output  32  instructions captured while in RUN.
REQ-017 SHALL have port fifo_count  output  log2(DEPTH)+1  current occupancy.
REQ-018 SHALL have ports halted, timeout, overflow  output  1 each  sticky status flags.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, HALTED, TIMEOUT; IDLE -> RUN unconditionally one cycle after reset deasserts.
REQ-020 In RUN, SHALL capture one entry per cycle: {pc, instr, alu_out, flags}, and increment retired_count (wraps at 2^32).
REQ-021 In IDLE, HALTED, TIMEOUT, SHALL capture nothing and hold retired_count.
REQ-022 SHALL go RUN -> HALTED when instr == 32'h00000073 (ecall); the ecall cycle itself is captured and counted.
REQ-023 SHALL keep a same-PC counter: increments when pc equals previous-cycle pc, else clears; at HALT_REPEAT, RUN -> HALTED (that cycle captured).
REQ-024 SHALL keep a RUN cycle counter; when it reaches TIMEOUT_CYCLES without halt, RUN -> TIMEOUT and timeout=1.
REQ-025 If halt and timeout conditions occur in the same cycle, HALTED SHALL win; timeout stays 0.
REQ-026 HALTED and TIMEOUT SHALL be terminal until rst; halted=1 in HALTED only.
REQ-027 FIFO pop SHALL occur when trace_valid && trace_ready; outputs show the new head next cycle (registered, first-word-fall-through).
REQ-028 Push SHALL be accepted if FIFO not full, or full with a pop in the same cycle.
REQ-029 A capture while full with no pop SHALL be dropped, set overflow=1 (sticky), and still count in retired_count.
REQ-030 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-031 Draining SHALL continue in HALTED/TIMEOUT until empty.
REQ-032 trace_* data outputs SHALL be don't-care when trace_valid=0; trace_valid SHALL never depend combinationally on trace_ready.

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE, FIFO empty, trace_valid=0, fifo_count=0, retired_count=0, halted=0, timeout=0, overflow=0, all internal counters 0.
REQ-034 rst mid-operation SHALL discard all FIFO contents and flags in that same edge; no entry captured in the reset cycle.
REQ-035 Previous-PC register SHALL reset to 0, so a first RUN pc of 0 counts as a repeat.

Verification
REQ-036 Reset, then pc 0,4,8,... with trace_ready=1 -> trace_valid from second RUN cycle, entries in order, retired_count increments by 1 per cycle.
REQ-037 trace_ready=0, DEPTH=16, 20 distinct RUN cycles -> fifo_count=16, overflow=1, retired_count=20, first 16 entries preserved on drain.
REQ-038 instr=32'h00000073 at pc=0x20 -> halted=1 next cycle, last entry pc=0x20, retired_count frozen.
REQ-039 pc held at 0x40 (jal x0,0) -> halted=1 after HALT_REPEAT=4 repeats, retired_count stops.
REQ-040 Distinct PCs for 200 RUN cycles -> timeout=1, halted=0, retired_count=200; ecall at cycle 200 instead -> halted=1, timeout=0.
REQ-041 Full FIFO with trace_ready=1 every cycle in RUN -> fifo_count stays 16, overflow stays 0; rst mid-stream -> all outputs at REQ-033 values next cycle.
